reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 108 ++++++++++
 tb/tb_reorder_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions: sizes and the per-entry record used by the
// ROB, reservation stations and issue logic.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 8;   // number of ROB entries (power of two)
   localparam int unsigned ROB_DW    = 16;  // result data width
   localparam int unsigned ROB_RW    = 4;   // architectural register index width
   localparam int unsigned ROB_TW    = 3;   // tag (entry index) width
   localparam int unsigned ROB_CW    = 4;   // occupancy counter width (0..DEPTH)

   // One ROB slot: in flight (busy), result present (ready), destination, result
   typedef struct packed {
      logic              busy;
      logic              ready;
      logic [ROB_RW-1:0] dest;
      logic [ROB_DW-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, captures results from the
// common data bus, forwards operands on query and retires the head in order.
// Ports:
//   clk1, rst                        clock, async active-high reset
//   alloc_valid/dest -> alloc_ready/tag   issue-side allocation
//   cdb_valid/tag/value              result broadcast
//   query_tag -> query_ready/value   operand forwarding lookup
//   commit_valid/dest/value          in-order retire to the register file
//   flush                            discard all in-flight entries
//   count, full, empty               occupancy status
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH,
   parameter int unsigned DW    = ROB_DW,
   parameter int unsigned RW    = ROB_RW
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [RW-1:0]     alloc_dest,
   output logic              alloc_ready,
   output logic [ROB_TW-1:0] alloc_tag,
   input  logic              cdb_valid,
   input  logic [ROB_TW-1:0] cdb_tag,
   input  logic [DW-1:0]     cdb_value,
   input  logic [ROB_TW-1:0] query_tag,
   output logic              query_ready,
   output logic [DW-1:0]     query_value,
   output logic              commit_valid,
   output logic [RW-1:0]     commit_dest,
   output logic [DW-1:0]     commit_value,
   input  logic              flush,
   output logic [ROB_CW-1:0] count,
   output logic              full,
   output logic              empty
);

   rob_entry_t        r_rob [DEPTH];
   logic [ROB_TW-1:0] r_head;
   logic [ROB_TW-1:0] r_tail;
   logic [ROB_CW-1:0] r_count;

   rob_entry_t        w_head_entry;
   rob_entry_t        w_query_entry;
   logic              w_full;
   logic              w_alloc;
   logic              w_commit;

   // Status and handshake terms, all from registered state
   assign w_full        = (r_count == ROB_CW'(DEPTH));
   assign w_head_entry  = r_rob[r_head];
   assign w_query_entry = r_rob[query_tag];
   assign w_alloc       = alloc_valid & ~w_full;
   assign w_commit      = w_head_entry.busy & w_head_entry.ready;

   assign alloc_ready  = ~w_full;
   assign alloc_tag    = r_tail;
   assign query_ready  = w_query_entry.busy & w_query_entry.ready;
   assign query_value  = w_query_entry.value;
   // Retire outputs stay visible during flush; the register file gates with !flush
   assign commit_valid = w_commit;
   assign commit_dest  = w_commit ? w_head_entry.dest  : '0;
   assign commit_value = w_commit ? w_head_entry.value : '0;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = (r_count == '0);

   // Entry array, pointers and occupancy
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_rob[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         // Values are left in place; busy=0 makes them invisible
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_rob[i].busy  <= 1'b0;
            r_rob[i].ready <= 1'b0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Results for entries not in flight are dropped
         if (cdb_valid && r_rob[cdb_tag].busy) begin
            r_rob[cdb_tag].ready <= 1'b1;
            r_rob[cdb_tag].value <= cdb_value;
         end
         if (w_commit) begin
            r_rob[r_head].busy <= 1'b0;
            r_head             <= r_head + ROB_TW'(1);
         end
         // Tail slot is never busy when allocating, so no overlap with CDB/commit
         if (w_alloc) begin
            r_rob[r_tail].busy  <= 1'b1;
            r_rob[r_tail].ready <= 1'b0;
            r_rob[r_tail].dest  <= alloc_dest;
            r_tail              <= r_tail + ROB_TW'(1);
         end
         r_count <= r_count + ROB_CW'(w_alloc) - ROB_CW'(w_commit);
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected retires, a
// negedge monitor pops and compares every commit the DUT presents.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic              clk1 = 1'b0;
   logic              rst;
   logic              alloc_valid;
   logic [ROB_RW-1:0] alloc_dest;
   logic              alloc_ready;
   logic [ROB_TW-1:0] alloc_tag;
   logic              cdb_valid;
   logic [ROB_TW-1:0] cdb_tag;
   logic [ROB_DW-1:0] cdb_value;
   logic [ROB_TW-1:0] query_tag;
   logic              query_ready;
   logic [ROB_DW-1:0] query_value;
   logic              commit_valid;
   logic [ROB_RW-1:0] commit_dest;
   logic [ROB_DW-1:0] commit_value;
   logic              flush;
   logic [ROB_CW-1:0] count;
   logic              full;
   logic              empty;

   typedef struct packed {
      logic [ROB_RW-1:0] dest;
      logic [ROB_DW-1:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   reorder_buffer dut (
      .clk1         (clk1),
      .rst          (rst),
      .alloc_valid  (alloc_valid),
      .alloc_dest   (alloc_dest),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_value    (cdb_value),
      .query_tag    (query_tag),
      .query_ready  (query_ready),
      .query_value  (query_value),
      .commit_valid (commit_valid),
      .commit_dest  (commit_dest),
      .commit_value (commit_value),
      .flush        (flush),
      .count        (count),
      .full         (full),
      .empty        (empty)
   );

   always #5 clk1 = ~clk1;

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [ROB_RW-1:0] d, input logic [ROB_DW-1:0] v);
      exp_t e;
      e.dest  = d;
      e.value = v;
      exp_q.push_back(e);
   endtask

   // Monitor: inputs are stable from posedge+1, so the negedge view is what the edge sees
   always @(negedge clk1) begin
      if (!rst && commit_valid && !flush) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL commit_unexpected: got dest %0h value %0h expected none",
                     commit_dest, commit_value);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (commit_dest !== e.dest || commit_value !== e.value) begin
               n_errors++;
               $display("FAIL commit: got dest %0h value %0h expected dest %0h value %0h",
                        commit_dest, commit_value, e.dest, e.value);
            end
         end
      end
   end

   // Watchdog: the directed sequence is far shorter than this
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      alloc_valid = 1'b0;
      alloc_dest  = '0;
      cdb_valid   = 1'b0;
      cdb_tag     = '0;
      cdb_value   = '0;
      query_tag   = '0;
      flush       = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_query_ready", 32'(query_ready), 32'd0);

      // Allocate dest 5,6,7 -> tags 0,1,2
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         alloc_dest  = ROB_RW'(5 + i);
         #1;
         chk("alloc_tag_a", 32'(alloc_tag), 32'(i));
         tick();
      end
      alloc_valid = 1'b0;
      #1;
      chk("count_3", 32'(count), 32'd3);
      chk("no_commit_3", 32'(commit_valid), 32'd0);

      // Results out of order; retire must be in order
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'h00AA;
      tick();
      chk("no_commit_tag1_only", 32'(commit_valid), 32'd0);
      cdb_tag = 3'd0; cdb_value = 16'h0011;
      push_exp(4'd5, 16'h0011);
      push_exp(4'd6, 16'h00AA);
      tick();
      cdb_valid = 1'b0;
      query_tag = 3'd1;
      #1;
      chk("query1_ready", 32'(query_ready), 32'd1);
      chk("query1_value", 32'(query_value), 32'h00AA);
      repeat (2) tick();
      chk("count_1", 32'(count), 32'd1);
      chk("no_commit_tag2", 32'(commit_valid), 32'd0);

      // Fill: head=2, tail=3; seven more allocations wrap 7->0
      for (int i = 0; i < 7; i++) begin
         alloc_valid = 1'b1;
         alloc_dest  = ROB_RW'(8 + i);
         #1;
         chk("alloc_tag_fill", 32'(alloc_tag), 32'((3 + i) % 8));
         tick();
      end
      chk("full_count", 32'(count), 32'd8);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
      alloc_dest = 4'd15;
      tick();
      chk("ninth_ignored_count", 32'(count), 32'd8);
      chk("ninth_ignored_tag", 32'(alloc_tag), 32'd2);
      // Head becomes ready while full with alloc_valid held high
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_value = 16'h0222;
      push_exp(4'd7, 16'h0222);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("full_commit_valid", 32'(commit_valid), 32'd1);
      chk("full_commit_no_alloc", 32'(alloc_ready), 32'd0);
      tick();
      chk("after_commit_count", 32'(count), 32'd7);
      chk("after_commit_full", 32'(full), 32'd0);
      chk("after_commit_tag", 32'(alloc_tag), 32'd2);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("refill_count", 32'(count), 32'd8);

      // Pipelined results: a retire every cycle for tags 3,4,5
      cdb_valid = 1'b1;
      cdb_tag = 3'd3; cdb_value = 16'h0333; push_exp(4'd8, 16'h0333);
      tick();
      cdb_tag = 3'd4; cdb_value = 16'h0444; push_exp(4'd9, 16'h0444);
      tick();
      cdb_tag = 3'd5; cdb_value = 16'h0555; push_exp(4'd10, 16'h0555);
      tick();
      cdb_tag = 3'd6; cdb_value = 16'h0666;
      tick();
      chk("pre_flush_count", 32'(count), 32'd5);
      // Flush while head is ready, with alloc and CDB active: retire suppressed
      flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 4'd3;
      cdb_tag = 3'd6; cdb_value = 16'h0777;
      #1;
      chk("flush_commit_visible", 32'(commit_valid), 32'd1);
      tick();
      flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
      query_tag = 3'd6;
      #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_tag", 32'(alloc_tag), 32'd0);
      chk("flush_query6", 32'(query_ready), 32'd0);
      chk("flush_no_commit", 32'(commit_valid), 32'd0);

      // CDB to non-busy entry is dropped
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 16'hBEEF;
      tick();
      cdb_valid = 1'b0;
      query_tag = 3'd4;
      #1;
      chk("drop_query4", 32'(query_ready), 32'd0);
      chk("drop_count", 32'(count), 32'd0);
      chk("drop_no_commit", 32'(commit_valid), 32'd0);

      // Single round trip after flush
      alloc_valid = 1'b1; alloc_dest = 4'd2;
      #1;
      chk("post_flush_tag", 32'(alloc_tag), 32'd0);
      tick();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 16'h1234;
      push_exp(4'd2, 16'h1234);
      tick();
      cdb_valid = 1'b0;
      tick();
      chk("round_trip_empty", 32'(empty), 32'd1);

      // Async reset between edges with three entries
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         alloc_dest  = ROB_RW'(1 + i);
         tick();
      end
      alloc_valid = 1'b0;
      #1;
      chk("pre_rst_count", 32'(count), 32'd3);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_empty", 32'(empty), 32'd1);
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_tag", 32'(alloc_tag), 32'd0);
      #3;
      rst = 1'b0;
      tick();
      chk("post_rst_empty", 32'(empty), 32'd1);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
